// File: rtl/ws2812_pkg.sv
// Shared types and elaboration-time timing arithmetic for the WS2812 stream controller.
package ws2812_pkg;

    typedef enum logic [2:0] {
        STOP  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Counter width that stays at least one bit even for a count of one.
    function automatic int width_of(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic int pixel_cycles(input int bpp, input int cpb);
        return 2 + bpp * cpb;
    endfunction

    function automatic int frame_cycles(input int np, input int bpp, input int cpb);
        return np * pixel_cycles(bpp, cpb);
    endfunction

    // The gap fills the frame period but never drops below the chain's latch time.
    function automatic int gap_cycles(input int period, input int latch,
                                      input int np, input int bpp, input int cpb);
        int slack;
        slack = period - frame_cycles(np, bpp, cpb);
        if (slack >= latch) begin
            return slack;
        end else begin
            return latch;
        end
    endfunction

endpackage

// File: rtl/ws2812_param_chk.sv
// Elaboration-time sanity checks on the controller configuration.
module ws2812_param_chk #(
    parameter int NUM_PIXELS     = 64,
    parameter int BITS_PER_PIXEL = 24,
    parameter int CYCLES_PER_BIT = 15,
    parameter int LATCH_CYCLES   = 600
) ();

    if (NUM_PIXELS < 1) begin : g_chk_pixels
        $error("ws2812: NUM_PIXELS must be >= 1");
    end
    if (BITS_PER_PIXEL < 1) begin : g_chk_bits
        $error("ws2812: BITS_PER_PIXEL must be >= 1");
    end
    if (CYCLES_PER_BIT < 1) begin : g_chk_cpb
        $error("ws2812: CYCLES_PER_BIT must be >= 1");
    end
    if (LATCH_CYCLES < 1) begin : g_chk_latch
        $error("ws2812: LATCH_CYCLES must be >= 1");
    end

endmodule

// File: rtl/ws2812_stream_ctrl_gap_timer.sv
// Loadable down-counter for the inter-frame gap; done is a registered pulse on the final count.
module ws2812_gap_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic             done_r;

    // Count down from the loaded value; flag the cycle the count reaches zero.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
            done_r  <= 1'b0;
        end else if (load) begin
            count_r <= value;
            done_r  <= (value == '0);
        end else if (count_r != '0) begin
            count_r <= count_r - ONE;
            done_r  <= (count_r == ONE);
        end else begin
            count_r <= count_r;
            done_r  <= 1'b0;
        end
    end

    assign done = done_r;

endmodule

// File: rtl/ws2812_stream_ctrl.sv
// Frame sequencer for a WS2812 chain: READ/LOAD/SHIFT per pixel, then a latch-safe GAP.
// All state advances on the falling edge of clk.
module ws2812_stream_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_PIXELS          = 64,
    parameter int BITS_PER_PIXEL      = 24,
    parameter int CYCLES_PER_BIT      = 15,
    parameter int FRAME_PERIOD_CYCLES = 375000,
    parameter int LATCH_CYCLES        = 600,
    parameter int NUM_FRAMES          = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic                                oneshot,
    input  logic                                start,
    input  logic                                hold_frame,
    output logic                                load_sreg,
    output logic                                transmit_pixel,
    output logic [width_of(NUM_PIXELS)-1:0]     pixel,
    output logic [width_of(NUM_FRAMES)-1:0]     frame,
    output logic                                frame_done,
    output logic                                busy
);

    localparam int SHIFT_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;
    localparam int GAP_CYCLES   = gap_cycles(FRAME_PERIOD_CYCLES, LATCH_CYCLES,
                                             NUM_PIXELS, BITS_PER_PIXEL, CYCLES_PER_BIT);

    localparam int PIX_W = width_of(NUM_PIXELS);
    localparam int FRM_W = width_of(NUM_FRAMES);
    localparam int PH_W  = width_of(SHIFT_CYCLES);
    localparam int GAP_W = width_of(GAP_CYCLES);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SHIFT_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t           state_r;
    logic [PH_W-1:0]  phase_r;
    logic [PIX_W-1:0] pixel_r;
    logic [FRM_W-1:0] frame_r;
    logic             load_sreg_r;
    logic             transmit_r;
    logic             busy_r;
    logic             gap_load_s;
    logic             gap_done_s;

    ws2812_param_chk #(
        .NUM_PIXELS     (NUM_PIXELS),
        .BITS_PER_PIXEL (BITS_PER_PIXEL),
        .CYCLES_PER_BIT (CYCLES_PER_BIT),
        .LATCH_CYCLES   (LATCH_CYCLES)
    ) u_param_chk ();

    // The gap timer is armed on the final SHIFT cycle of the last pixel.
    always_comb begin
        gap_load_s = 1'b0;
        if ((state_r == SHIFT) && (phase_r == PH_LAST) && (pixel_r == PIX_LAST)) begin
            gap_load_s = 1'b1;
        end else begin
            gap_load_s = 1'b0;
        end
    end

    ws2812_gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (gap_load_s),
        .value (GAP_LOAD),
        .done  (gap_done_s)
    );

    // Sequencer FSM; outputs are registered alongside the state they describe.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_r     <= STOP;
            phase_r     <= '0;
            pixel_r     <= '0;
            frame_r     <= '0;
            load_sreg_r <= 1'b0;
            transmit_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                STOP: begin
                    load_sreg_r <= 1'b0;
                    transmit_r  <= 1'b0;
                    phase_r     <= '0;
                    if (enable && (!oneshot || start)) begin
                        state_r <= READ;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= STOP;
                        busy_r  <= 1'b0;
                    end
                end
                READ: begin
                    state_r     <= LOAD;
                    load_sreg_r <= 1'b1;
                    transmit_r  <= 1'b0;
                    busy_r      <= 1'b1;
                end
                LOAD: begin
                    state_r     <= SHIFT;
                    load_sreg_r <= 1'b0;
                    transmit_r  <= 1'b1;
                    phase_r     <= '0;
                    busy_r      <= 1'b1;
                end
                SHIFT: begin
                    load_sreg_r <= 1'b0;
                    busy_r      <= 1'b1;
                    if (phase_r == PH_LAST) begin
                        phase_r    <= '0;
                        transmit_r <= 1'b0;
                        if (pixel_r != PIX_LAST) begin
                            pixel_r <= pixel_r + PIX_ONE;
                            state_r <= READ;
                        end else begin
                            pixel_r <= '0;
                            state_r <= GAP;
                        end
                    end else begin
                        phase_r    <= phase_r + PH_ONE;
                        transmit_r <= 1'b1;
                    end
                end
                GAP: begin
                    load_sreg_r <= 1'b0;
                    transmit_r  <= 1'b0;
                    if (gap_done_s) begin
                        // Mode inputs are only looked at here and at the STOP exit.
                        if (!hold_frame) begin
                            frame_r <= (frame_r == FRM_LAST) ? '0 : frame_r + FRM_ONE;
                        end else begin
                            frame_r <= frame_r;
                        end
                        if (enable && !oneshot) begin
                            state_r <= READ;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= STOP;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= GAP;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= STOP;
                    phase_r     <= '0;
                    pixel_r     <= '0;
                    load_sreg_r <= 1'b0;
                    transmit_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign load_sreg      = load_sreg_r;
    assign transmit_pixel = transmit_r;
    assign pixel          = pixel_r;
    assign frame          = frame_r;
    assign frame_done     = gap_done_s;
    assign busy           = busy_r;

endmodule

// File: tb/tb_ws2812_stream_ctrl.sv
// Directed bench: 4 pixels x 3 bits x 2 cycles (8-cycle pixel, 32-cycle frame), 28-cycle gap;
// a second instance with a 35-cycle period exercises the 10-cycle latch clamp.
module tb_ws2812_stream_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic oneshot = 1'b0;
    logic start = 1'b0;
    logic hold_frame = 1'b0;

    logic       load_sreg, transmit_pixel, frame_done, busy;
    logic [1:0] pixel, frame;
    logic       c_load, c_tx, c_fd, c_busy;
    logic [1:0] c_pixel, c_frame;

    int n_checks = 0;
    int n_errors = 0;

    int load_t[$];
    int pix_load[$];
    int fd_t[$];
    int fdc_t[$];
    int tx_cnt;
    int frame_nz;

    always #5 clk = ~clk;

    ws2812_stream_ctrl #(
        .NUM_PIXELS(4), .BITS_PER_PIXEL(3), .CYCLES_PER_BIT(2),
        .FRAME_PERIOD_CYCLES(60), .LATCH_CYCLES(10), .NUM_FRAMES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .oneshot(oneshot),
        .start(start), .hold_frame(hold_frame), .load_sreg(load_sreg),
        .transmit_pixel(transmit_pixel), .pixel(pixel), .frame(frame),
        .frame_done(frame_done), .busy(busy)
    );

    ws2812_stream_ctrl #(
        .NUM_PIXELS(4), .BITS_PER_PIXEL(3), .CYCLES_PER_BIT(2),
        .FRAME_PERIOD_CYCLES(35), .LATCH_CYCLES(10), .NUM_FRAMES(3)
    ) dut_clamp (
        .clk(clk), .rst_n(rst_n), .enable(enable), .oneshot(oneshot),
        .start(start), .hold_frame(hold_frame), .load_sreg(c_load),
        .transmit_pixel(c_tx), .pixel(c_pixel), .frame(c_frame),
        .frame_done(c_fd), .busy(c_busy)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        else return -1;
    endfunction

    // Hold reset across two falling edges; returns on a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        load_t.delete(); pix_load.delete(); fd_t.delete(); fdc_t.delete();
        tx_cnt = 0;
        frame_nz = 0;
    endtask

    // Sample one cycle (rising edge, away from the falling active edge) and log events.
    task automatic sample(input int i);
        @(posedge clk);
        if (load_sreg) begin
            load_t.push_back(i);
            pix_load.push_back(int'(pixel));
        end
        if (transmit_pixel) tx_cnt++;
        if (frame_done) fd_t.push_back(i);
        if (c_fd) fdc_t.push_back(i);
        if (frame != 2'd0) frame_nz++;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_load", int'(load_sreg), 0);
        check_eq("rst_tx", int'(transmit_pixel), 0);
        check_eq("rst_pixel", int'(pixel), 0);
        check_eq("rst_frame", int'(frame), 0);
        check_eq("rst_fd", int'(frame_done), 0);
        check_eq("rst_busy", int'(busy), 0);

        // Continuous run
        enable = 1'b1; oneshot = 1'b0;
        do_reset();
        for (int i = 1; i <= 185; i++) begin
            sample(i);
            if (i == 1) begin
                check_eq("cont_busy", int'(busy), 1);
                check_eq("cont_frame0", int'(frame), 0);
                check_eq("clamp_busy", int'(c_busy), 1);
            end
            if (i == 2) check_eq("clamp_load", int'(c_load), 1);
            if (i == 3) check_eq("clamp_tx", int'(c_tx), 1);
            if (i == 10) check_eq("clamp_pixel1", int'(c_pixel), 1);
            if (i == 43) check_eq("clamp_frame1", int'(c_frame), 1);
            if (i == 60) begin
                check_eq("cont_tx_frame", tx_cnt, 24);
                check_eq("cont_loads_frame", load_t.size(), 4);
            end
            if (i == 61) check_eq("cont_frame1", int'(frame), 1);
            if (i == 121) check_eq("cont_frame2", int'(frame), 2);
            if (i == 181) check_eq("cont_frame_wrap", int'(frame), 0);
        end
        check_eq("cont_first_load", q_at(load_t, 0), 2);
        check_eq("cont_load_spacing", q_at(load_t, 1) - q_at(load_t, 0), 8);
        check_eq("cont_load_spacing3", q_at(load_t, 3) - q_at(load_t, 2), 8);
        for (int k = 0; k < 4; k++) check_eq($sformatf("cont_pix_at_load%0d", k), q_at(pix_load, k), k);
        check_eq("cont_fd_first", q_at(fd_t, 0), 60);
        check_eq("cont_fd_period", q_at(fd_t, 1) - q_at(fd_t, 0), 60);
        check_eq("cont_fd_period2", q_at(fd_t, 2) - q_at(fd_t, 1), 60);
        check_eq("clamp_fd_first", q_at(fdc_t, 0), 42);
        check_eq("clamp_fd_period", q_at(fdc_t, 1) - q_at(fdc_t, 0), 42);

        // One-shot
        enable = 1'b1; oneshot = 1'b1; start = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) sample(i);
        check_eq("os_idle_busy", int'(busy), 0);
        check_eq("os_idle_loads", load_t.size(), 0);
        start = 1'b1;
        for (int j = 1; j <= 80; j++) begin
            sample(j);
            if (j == 1) begin
                start = 1'b0;
                check_eq("os_busy_start", int'(busy), 1);
            end
            if (j == 20) start = 1'b1;
            if (j == 21) start = 1'b0;
            if (j == 60) check_eq("os_busy_at_fd", int'(busy), 1);
            if (j == 61) begin
                check_eq("os_busy_after_fd", int'(busy), 0);
                check_eq("os_frame", int'(frame), 1);
            end
        end
        check_eq("os_loads", load_t.size(), 4);
        check_eq("os_fd_count", fd_t.size(), 1);
        check_eq("os_fd_time", q_at(fd_t, 0), 60);

        // Enable drop during pixel 1 SHIFT
        enable = 1'b1; oneshot = 1'b0;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            sample(i);
            if (i == 12) enable = 1'b0;
            if (i == 61) begin
                check_eq("drop_busy_after", int'(busy), 0);
                check_eq("drop_frame", int'(frame), 1);
            end
        end
        check_eq("drop_loads", load_t.size(), 4);
        check_eq("drop_pix2", q_at(pix_load, 2), 2);
        check_eq("drop_pix3", q_at(pix_load, 3), 3);
        check_eq("drop_tx", tx_cnt, 24);
        check_eq("drop_fd_count", fd_t.size(), 1);
        check_eq("drop_fd_time", q_at(fd_t, 0), 60);

        // Hold frame
        enable = 1'b1; oneshot = 1'b0; hold_frame = 1'b1;
        do_reset();
        for (int i = 1; i <= 185; i++) sample(i);
        check_eq("hold_fd_count", fd_t.size(), 3);
        check_eq("hold_frame_nz", frame_nz, 0);
        hold_frame = 1'b0;

        // Reset during pixel 2 SHIFT
        enable = 1'b1; oneshot = 1'b0;
        do_reset();
        for (int i = 1; i <= 23; i++) begin
            sample(i);
            if (i == 20) begin
                check_eq("mid_pixel2", int'(pixel), 2);
                check_eq("mid_tx", int'(transmit_pixel), 1);
                rst_n = 1'b0;
            end
            if (i == 21) begin
                check_eq("mid_rst_load", int'(load_sreg), 0);
                check_eq("mid_rst_tx", int'(transmit_pixel), 0);
                check_eq("mid_rst_pixel", int'(pixel), 0);
                check_eq("mid_rst_frame", int'(frame), 0);
                check_eq("mid_rst_fd", int'(frame_done), 0);
                check_eq("mid_rst_busy", int'(busy), 0);
                rst_n = 1'b1;
            end
            if (i == 22) check_eq("mid_restart_busy", int'(busy), 1);
            if (i == 23) begin
                check_eq("mid_restart_load", int'(load_sreg), 1);
                check_eq("mid_restart_pixel", int'(pixel), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
